// File: rtl/bp_pkg.sv
// Shared branch-predictor package.
//   clog2     : index width for a power-of-two table depth
//   ctr_init  : weakly-not-taken reset value for a counter of given width
//   BP_*      : default table geometry
package bp_pkg;

  localparam int BP_ENTRIES   = 64;
  localparam int BP_CTR_WIDTH = 2;
  localparam int BP_PC_LSB    = 2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // 2^(width-1)-1: MSB clear, all lower bits set (0 for width 1).
  function automatic int ctr_init(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_next.sv
// Next-value logic for one saturating up/down counter.
//   i_ctr   : current counter value
//   i_taken : 1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
//   o_next  : value to write back
module bp_sat_counter_next #(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] i_ctr,
  input  logic                 i_taken,
  output logic [CTR_WIDTH-1:0] o_next
);

  localparam logic [CTR_WIDTH-1:0] ONE = CTR_WIDTH'(1);

  always_comb begin
    o_next = i_ctr;
    if (i_taken) begin
      if (i_ctr != '1) o_next = i_ctr + ONE;
    end else begin
      if (i_ctr != '0) o_next = i_ctr - ONE;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: ENTRIES saturating counters indexed by PC.
// Lookup is combinational (read-before-write vs. a same-cycle update);
// the returned index travels with the instruction and comes back on update.
// Also keeps saturating branch / mispredict statistics.
//
// Optional feature: define BHT_GSHARE_EN to XOR a global history register
// into the lookup index (updates still use update_idx as supplied).
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   lookup_pc          : PC of instruction in ID
//   lookup_taken       : prediction (counter MSB), combinational
//   lookup_idx         : table index used for this lookup
//   update_valid       : resolution strobe
//   update_is_branch   : gate; non-branches leave table and stats untouched
//   update_idx         : index returned at lookup time
//   update_taken       : resolved outcome
//   update_mispredict  : resolved prediction was wrong (stats only)
//   branch_count       : applied updates, saturating
//   mispredict_count   : mispredicted applied updates, saturating
module bht_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES    = BP_ENTRIES,
  parameter  int CTR_WIDTH  = BP_CTR_WIDTH,
  parameter  int PC_LSB     = BP_PC_LSB,
  parameter  int STAT_WIDTH = 32,
  localparam int IDX_W      = clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           lookup_pc,
  output logic                  lookup_taken,
  output logic [IDX_W-1:0]      lookup_idx,
  input  logic                  update_valid,
  input  logic                  update_is_branch,
  input  logic [IDX_W-1:0]      update_idx,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam logic [CTR_WIDTH-1:0]  CTR_INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic [CTR_WIDTH-1:0] r_tbl [ENTRIES];
  logic [STAT_WIDTH-1:0] r_br_cnt;
  logic [STAT_WIDTH-1:0] r_mis_cnt;

  logic                 w_apply;
  logic [IDX_W-1:0]     w_pc_idx;
  logic [CTR_WIDTH-1:0] w_ctr_next;
  logic                 w_unused_pc;

  assign w_apply     = update_valid & update_is_branch;
  assign w_pc_idx    = lookup_pc[PC_LSB +: IDX_W];
  assign w_unused_pc = ^lookup_pc;

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // Shift in the resolved outcome; the shift form also covers IDX_W == 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_ghr <= '0;
    else if (w_apply) r_ghr <= (r_ghr << 1) | IDX_W'(update_taken);
  end

  assign lookup_idx = w_pc_idx ^ r_ghr;
`else
  assign lookup_idx = w_pc_idx;
`endif

  // Plain array read: a same-cycle update is not bypassed.
  assign lookup_taken = r_tbl[lookup_idx][CTR_WIDTH-1];

  bp_sat_counter_next #(.CTR_WIDTH(CTR_WIDTH)) u_ctr_next (
    .i_ctr   (r_tbl[update_idx]),
    .i_taken (update_taken),
    .o_next  (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= CTR_INIT;
    end else if (w_apply) begin
      r_tbl[update_idx] <= w_ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_apply) begin
      if (r_br_cnt != '1)                      r_br_cnt  <= r_br_cnt + STAT_ONE;
      if (update_mispredict && r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + STAT_ONE;
    end
  end

  assign branch_count     = r_br_cnt;
  assign mispredict_count = r_mis_cnt;

endmodule
